// File: rtl/magcmp_seq.sv
// Sequential magnitude comparator: walks the latched operands one SLICE-bit slice per cycle,
// MSB slice first, terminating early on the first differing slice and falling back to cas_in.
module magcmp_seq #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   input  logic [2:0]       cas_in,
   output logic [2:0]       y,
   output logic             busy,
   output logic             done
);

   localparam int NS = WIDTH / SLICE;
   localparam int IW = (NS > 1) ? $clog2(NS) : 1;

   typedef enum logic {IDLE, CMP} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] a_r, b_r;
   logic             sm_r;
   logic [2:0]       cas_r;
   logic [IW-1:0]    idx, idx_n;
   logic [2:0]       y_n;
   logic             done_n;
   logic             load;
   logic [SLICE-1:0] a_sl, b_sl;
   logic [2:0]       cas_res;

   // Slice under test; in signed mode the sign bit is inverted so an unsigned compare orders correctly
   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int unsigned s = 0; s < NS; s++) begin
         if (idx == IW'(s)) begin
            a_sl = a_r[s*SLICE +: SLICE];
            b_sl = b_r[s*SLICE +: SLICE];
         end
      end
      if (sm_r && (idx == IW'(NS-1))) begin
         a_sl[SLICE-1] = ~a_sl[SLICE-1];
         b_sl[SLICE-1] = ~b_sl[SLICE-1];
      end
   end

   always_comb begin
      cas_res = 3'b010;
      if (!cas_r[1]) begin
         case ({cas_r[2], cas_r[0]})
            2'b10:   cas_res = 3'b100;
            2'b01:   cas_res = 3'b001;
            2'b11:   cas_res = 3'b000;
            default: cas_res = 3'b101;
         endcase
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      y_n     = y;
      done_n  = 1'b0;
      load    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               idx_n   = IW'(NS-1);
               state_n = CMP;
            end
         end
         CMP: begin
            if (a_sl > b_sl) begin
               y_n     = 3'b100;
               done_n  = 1'b1;
               state_n = IDLE;
            end else if (a_sl < b_sl) begin
               y_n     = 3'b001;
               done_n  = 1'b1;
               state_n = IDLE;
            end else if (idx == '0) begin
               y_n     = cas_res;
               done_n  = 1'b1;
               state_n = IDLE;
            end else begin
               idx_n = idx - IW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= IW'(NS-1);
         y     <= '0;
         done  <= 1'b0;
         a_r   <= '0;
         b_r   <= '0;
         sm_r  <= 1'b0;
         cas_r <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         y     <= y_n;
         done  <= done_n;
         if (load) begin
            a_r   <= a;
            b_r   <= b;
            sm_r  <= signed_mode;
            cas_r <= cas_in;
         end
      end
   end

   assign busy = (state == CMP);

endmodule
